// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and the sync bundle type used by the
// sync generator and the pixel-path blocks.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned VGA_CNTR_WIDTH_H = 11;
    localparam int unsigned VGA_CNTR_WIDTH_V = 10;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_bundle_t;

endpackage

// File: rtl/vga_sync_generator_if.sv
// Bundle of the sync generator's timing outputs as seen by the pixel path.
interface vga_sync_generator_if #(
    parameter int unsigned CNTR_WIDTH_H = 11,
    parameter int unsigned CNTR_WIDTH_V = 10
);
    logic [CNTR_WIDTH_H-1:0] CounterX;
    logic [CNTR_WIDTH_V-1:0] CounterY;
    logic                    inDisplayArea;
    logic                    FrameStart;
    logic                    VGA_HS;
    logic                    VGA_VS;
    logic                    VGA_BLANK_N;
    logic                    VGA_SYNC_N;

    modport master (
        output CounterX, CounterY, inDisplayArea, FrameStart,
               VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );

    modport slave (
        input  CounterX, CounterY, inDisplayArea, FrameStart,
               VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth register delay for sync/blank bits; DEPTH = 0 is a plain wire.
module sync_delay_line #(
    parameter int unsigned       WIDTH     = 3,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge CLOCK or negedge RESET_N) begin
            if (!RESET_N) begin
                for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
            end else begin
                stage[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end
endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster counters with sync/blank generation, aligned to a downstream
// pixel path of PIPE_DELAY cycles.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_FP         = VGA_H_FP,
    parameter int unsigned H_SYNC       = VGA_H_SYNC,
    parameter int unsigned H_BP         = VGA_H_BP,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_FP         = VGA_V_FP,
    parameter int unsigned V_SYNC       = VGA_V_SYNC,
    parameter int unsigned V_BP         = VGA_V_BP,
    parameter int unsigned CNTR_WIDTH_H = VGA_CNTR_WIDTH_H,
    parameter int unsigned CNTR_WIDTH_V = VGA_CNTR_WIDTH_V,
    parameter int unsigned PIPE_DELAY   = 1,
    parameter bit          SYNC_POL     = 1'b0
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    output logic [CNTR_WIDTH_H-1:0] CounterX,
    output logic [CNTR_WIDTH_V-1:0] CounterY,
    output logic                    inDisplayArea,
    output logic                    FrameStart,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    VGA_BLANK_N,
    output logic                    VGA_SYNC_N
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint unsigned H_RANGE = 64'd1 << CNTR_WIDTH_H;
    localparam longint unsigned V_RANGE = 64'd1 << CNTR_WIDTH_V;

    if (longint'(H_TOTAL) > H_RANGE) begin : g_bad_h
        $error("vga_sync_generator: H_TOTAL exceeds CounterX range");
    end
    if (longint'(V_TOTAL) > V_RANGE) begin : g_bad_v
        $error("vga_sync_generator: V_TOTAL exceeds CounterY range");
    end
    if (PIPE_DELAY > 4) begin : g_bad_pipe
        $error("vga_sync_generator: PIPE_DELAY must be 0..4");
    end

    localparam logic [CNTR_WIDTH_H-1:0] H_LAST       = CNTR_WIDTH_H'(H_TOTAL - 1);
    localparam logic [CNTR_WIDTH_H-1:0] H_ACT        = CNTR_WIDTH_H'(H_ACTIVE);
    localparam logic [CNTR_WIDTH_H-1:0] H_SYNC_START = CNTR_WIDTH_H'(H_ACTIVE + H_FP);
    localparam logic [CNTR_WIDTH_H-1:0] H_SYNC_END   = CNTR_WIDTH_H'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNTR_WIDTH_V-1:0] V_LAST       = CNTR_WIDTH_V'(V_TOTAL - 1);
    localparam logic [CNTR_WIDTH_V-1:0] V_ACT        = CNTR_WIDTH_V'(V_ACTIVE);
    localparam logic [CNTR_WIDTH_V-1:0] V_SYNC_START = CNTR_WIDTH_V'(V_ACTIVE + V_FP);
    localparam logic [CNTR_WIDTH_V-1:0] V_SYNC_END   = CNTR_WIDTH_V'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_bundle_t IDLE_BUNDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank_n: 1'b0};

    logic [CNTR_WIDTH_H-1:0] next_x;
    logic [CNTR_WIDTH_V-1:0] next_y;
    logic                    x_wrap;
    logic                    frame_wrap;
    logic                    hs_next;
    logic                    vs_next;
    logic                    disp_next;
    logic                    hs_u;
    logic                    vs_u;
    sync_bundle_t            bundle_u;
    sync_bundle_t            bundle_d;

    always_comb begin
        x_wrap     = (CounterX == H_LAST);
        frame_wrap = x_wrap && (CounterY == V_LAST);
        next_x     = x_wrap ? '0 : CounterX + CNTR_WIDTH_H'(1);
        next_y     = CounterY;
        if (x_wrap) next_y = (CounterY == V_LAST) ? '0 : CounterY + CNTR_WIDTH_V'(1);
        hs_next   = (next_x >= H_SYNC_START && next_x < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vs_next   = (next_y >= V_SYNC_START && next_y < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        disp_next = (next_x < H_ACT) && (next_y < V_ACT);
    end

    // Undelayed sync/blank are decoded from the next counter values so they
    // track the counters exactly, yet still hold inactive levels during reset.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            CounterX      <= '0;
            CounterY      <= '0;
            FrameStart    <= 1'b0;
            inDisplayArea <= 1'b0;
            hs_u          <= ~SYNC_POL;
            vs_u          <= ~SYNC_POL;
        end else begin
            CounterX      <= next_x;
            CounterY      <= next_y;
            FrameStart    <= frame_wrap;
            inDisplayArea <= disp_next;
            hs_u          <= hs_next;
            vs_u          <= vs_next;
        end
    end

    assign bundle_u = '{hs: hs_u, vs: vs_u, blank_n: inDisplayArea};

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (IDLE_BUNDLE)
    ) u_sync_delay (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .din     (bundle_u),
        .dout    (bundle_d)
    );

    assign VGA_HS      = bundle_d.hs;
    assign VGA_VS      = bundle_d.vs;
    assign VGA_BLANK_N = bundle_d.blank_n;
    assign VGA_SYNC_N  = 1'b0;
endmodule

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal front porch, sync, back porch in pixels; H_TOTAL = sum of all four = 800.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical equivalents in lines; V_TOTAL = 525.
REQ-004 Parameters CNTR_WIDTH_H = 11 and CNTR_WIDTH_V = 10: counter widths.
REQ-005 Parameter PIPE_DELAY, default 1, range 0..4: cycles of downstream pixel-path latency to which sync/blank outputs are aligned.
REQ-006 Parameter SYNC_POL, default 0: active level of VGA_HS/VGA_VS.
REQ-007 The block has one clock; reset is asynchronous and active-low.
REQ-008 Port CLOCK  input  1  pixel clock; all state updates on its rising edge.
REQ-009 Port RESET_N  input  1  asynchronous active-low reset.
REQ-010 Port CounterX  output  CNTR_WIDTH_H  current pixel column, undelayed.
REQ-011 Port CounterY  output  CNTR_WIDTH_V  current line, undelayed.
REQ-012 Port inDisplayArea  output  1  high when CounterX < H_ACTIVE and CounterY < V_ACTIVE, undelayed.
REQ-013 Port FrameStart  output  1  one-cycle pulse when CounterX = 0 and CounterY = 0, undelayed.
REQ-014 Port VGA_HS  output  1  horizontal sync, delayed PIPE_DELAY cycles.
REQ-015 Port VGA_VS  output  1  vertical sync, delayed PIPE_DELAY cycles.
REQ-016 Port VGA_BLANK_N  output  1  inDisplayArea delayed PIPE_DELAY cycles.
REQ-017 Port VGA_SYNC_N  output  1  constant 0 (DAC sync-on-green unused).

Function
REQ-018 CounterX SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-019 CounterY SHALL increment only in the cycle where CounterX wraps, and wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-020 When CounterX = H_TOTAL-1 and CounterY = V_TOTAL-1, both counters SHALL become 0 on the next edge, with FrameStart high in that next cycle.
REQ-021 The undelayed HS SHALL be active for H_ACTIVE+H_FP <= CounterX < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
REQ-022 The undelayed VS SHALL be active for V_ACTIVE+V_FP <= CounterY < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
REQ-023 "Active" SHALL mean level SYNC_POL; inactive SHALL mean ~SYNC_POL.
REQ-024 VGA_HS, VGA_VS and VGA_BLANK_N SHALL equal their undelayed values from exactly PIPE_DELAY cycles earlier.
REQ-025 With PIPE_DELAY = 0, these outputs SHALL be registered copies with no extra delay beyond the counter register, i.e. combinational from the counters.
REQ-026 Counter comparisons SHALL be unsigned at full counter width; parameter sets whose totals exceed counter range are illegal and SHALL fail at elaboration.

Reset
REQ-027 While RESET_N is low: CounterX = 0, CounterY = 0, FrameStart = 0, inDisplayArea = 0, VGA_HS = VGA_VS = ~SYNC_POL, VGA_BLANK_N = 0, and every delay stage holds the inactive value.
REQ-028 Assertion of RESET_N SHALL take effect immediately regardless of CLOCK, including mid-line and mid-frame.
REQ-029 On the first rising edge after deassertion, counting SHALL begin: CounterX = 0 → 1.
REQ-030 FrameStart SHALL not pulse during or immediately after reset until the counters next pass (0,0) by wrap.

Structure
REQ-031 Timing defaults (the H_*/V_* values, H_TOTAL, V_TOTAL) and counter widths SHALL reside in a shared package vga_timing_pkg, also used by the pixel-path blocks.
REQ-032 The PIPE_DELAY alignment SHALL be one sub-module, sync_delay_line, parameterised by width and depth and instanced once for the 3-bit {HS, VS, BLANK} bundle.

Verification
REQ-033 Reset release -> CounterX steps 0,1,2…; VGA_HS = 1 and VGA_BLANK_N = 0 for the first PIPE_DELAY cycles.
REQ-034 Line wrap -> at CounterX = 799 the next cycle gives CounterX = 0 and CounterY incremented by 1; no increment on any other cycle.
REQ-035 HS window at PIPE_DELAY = 1 -> VGA_HS is low exactly when the previous-cycle CounterX was 656..751 (96 cycles per line).
REQ-036 Frame wrap -> (799,524) → (0,0) with FrameStart high for one cycle; VS low for exactly 2 lines (1600 cycles) per frame.
REQ-037 RESET_N pulsed low at CounterX = 300, CounterY = 200 -> outputs reach reset values asynchronously; counting restarts from (0,0) with no FrameStart pulse.
REQ-038 Blanking count -> over one full frame, VGA_BLANK_N is high for exactly 307200 cycles.
